// File: rtl/dmem_access_ctrl_if.sv
// Data-memory port bundle between the MEM-stage access controller and the data memory.
// master (controller): drives mem_req/mem_we/mem_addr/mem_wdata, receives mem_ready/mem_rdata.
// slave  (memory):     receives the request fields, drives mem_ready/mem_rdata.
interface dmem_access_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_ready;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access controller.
// Sequences one load/store per MEM-stage instruction onto a req/ready memory port,
// stalls IF..MEM until the access completes, resolves WB->MEM store-data forwarding
// at issue time and returns registered load data to the MEM/WB latch.
// Ports:
//   clk, rst                         clock, async active-high reset
//   MemRead, MemWrite, addr, wdata   EX/MEM access request
//   EX_MEM_rs2, MEM_WB_rd,
//   MEM_WB_RegWrite, wb_data         store-data forwarding sources
//   flush                            squash the MEM-stage instruction
//   mem                              data-memory port (master side)
//   mem_stall                        combinational pipeline freeze
//   load_data, load_valid            registered load result and one-cycle valid
module dmem_access_ctrl #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            MemRead,
    input  logic            MemWrite,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      EX_MEM_rs2,
    input  logic [4:0]      MEM_WB_rd,
    input  logic            MEM_WB_RegWrite,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    dmem_access_ctrl_if.master mem,
    output logic            mem_stall,
    output logic [XLEN-1:0] load_data,
    output logic            load_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic [XLEN-1:0] load_data_q, load_data_d;
    logic            load_valid_q, load_valid_d;
    logic            flushed_q, flushed_d;

    logic            access_c;
    logic            fwd_c;

    assign access_c = (MemRead | MemWrite) & ~flush;
    assign fwd_c    = MemWrite & MEM_WB_RegWrite & (MEM_WB_rd != 5'd0) & (MEM_WB_rd == EX_MEM_rs2);

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            flushed_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            flushed_q    <= flushed_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        flushed_d    = flushed_q;

        case (state_q)
            IDLE: begin
                if (access_c) begin
                    // A simultaneous read+write is issued as a plain load
                    mem_addr_d  = addr;
                    mem_we_d    = MemWrite & ~MemRead;
                    mem_wdata_d = fwd_c ? wb_data : wdata;
                    mem_req_d   = 1'b1;
                    flushed_d   = 1'b0;
                    state_d     = REQ;
                end
            end
            REQ: begin
                // A flush cannot withdraw an outstanding request; it only hides the result
                if (flush) begin
                    flushed_d = 1'b1;
                end
                if (mem.mem_ready) begin
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        load_data_d  = mem.mem_rdata;
                        load_valid_d = ~(flushed_q | flush);
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                // Pipeline advances this cycle, so never reissue from here
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;

    assign mem_stall  = ~rst & (((state_q == IDLE) & access_c) | (state_q == REQ));
    assign load_data  = load_data_q;
    assign load_valid = load_valid_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed scenarios plus randomized traffic,
// compared every cycle against a transaction-level reference model.
module tb_dmem_access_ctrl;

    localparam int unsigned XLEN = 32;

    logic            clk;
    logic            rst;
    logic            MemRead;
    logic            MemWrite;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [4:0]      EX_MEM_rs2;
    logic [4:0]      MEM_WB_rd;
    logic            MEM_WB_RegWrite;
    logic [XLEN-1:0] wb_data;
    logic            flush;
    logic            mem_stall;
    logic [XLEN-1:0] load_data;
    logic            load_valid;

    dmem_access_ctrl_if #(.XLEN(XLEN)) mem ();

    dmem_access_ctrl #(.XLEN(XLEN)) dut (
        .clk             (clk),
        .rst             (rst),
        .MemRead         (MemRead),
        .MemWrite        (MemWrite),
        .addr            (addr),
        .wdata           (wdata),
        .EX_MEM_rs2      (EX_MEM_rs2),
        .MEM_WB_rd       (MEM_WB_rd),
        .MEM_WB_RegWrite (MEM_WB_RegWrite),
        .wb_data         (wb_data),
        .flush           (flush),
        .mem             (mem.master),
        .mem_stall       (mem_stall),
        .load_data       (load_data),
        .load_valid      (load_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: one access in flight, described by what has been issued
    // and whether it is waiting on memory or in its completion cycle.
    bit              m_waiting;
    bit              m_completing;
    bit              m_squashed;
    bit              m_we;
    logic [XLEN-1:0] m_addr;
    logic [XLEN-1:0] m_wdata;
    logic [XLEN-1:0] m_load_data;
    bit              m_load_valid;

    task automatic model_reset();
        m_waiting    = 0;
        m_completing = 0;
        m_squashed   = 0;
        m_we         = 0;
        m_addr       = '0;
        m_wdata      = '0;
        m_load_data  = '0;
        m_load_valid = 0;
    endtask

    // Compare outputs for the current cycle, then advance model and clock
    task automatic cycle();
        bit access;
        bit exp_stall;
        bit fwd;
        #2;
        access    = (MemRead || MemWrite) && !flush;
        exp_stall = m_waiting || (!m_waiting && !m_completing && access);
        check("mem_req",    32'(mem.mem_req),   32'(m_waiting));
        check("mem_we",     32'(mem.mem_we),    32'(m_we));
        check("mem_addr",   mem.mem_addr,       m_addr);
        check("mem_wdata",  mem.mem_wdata,      m_wdata);
        check("mem_stall",  32'(mem_stall),     32'(exp_stall));
        check("load_valid", 32'(load_valid),    32'(m_completing && m_load_valid));
        check("load_data",  load_data,          m_load_data);

        if (m_completing) begin
            m_completing = 0;
            m_load_valid = 0;
        end else if (m_waiting) begin
            if (flush) m_squashed = 1;
            if (mem.mem_ready) begin
                m_waiting    = 0;
                m_completing = 1;
                if (!m_we) begin
                    m_load_data  = mem.mem_rdata;
                    m_load_valid = !m_squashed;
                end
            end
        end else if (access) begin
            fwd = MemWrite && MEM_WB_RegWrite && (MEM_WB_rd != 0) && (MEM_WB_rd == EX_MEM_rs2);
            m_addr     = addr;
            m_we       = MemWrite && !MemRead;
            m_wdata    = fwd ? wb_data : wdata;
            m_waiting  = 1;
            m_squashed = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        MemRead = 0; MemWrite = 0; flush = 0;
        MEM_WB_RegWrite = 0; MEM_WB_rd = '0; EX_MEM_rs2 = '0;
        mem.mem_ready = 0; mem.mem_rdata = '0;
    endtask

    initial begin
        rst = 1;
        addr = '0; wdata = '0; wb_data = '0;
        idle_inputs();
        model_reset();
        MemRead = 1;
        #3;
        check("rst_stall", 32'(mem_stall), 32'd0);
        check("rst_req",   32'(mem.mem_req), 32'd0);
        check("rst_ldata", load_data, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 0;
        idle_inputs();
        cycle();

        // Zero-wait load
        MemRead = 1; addr = 32'h100; mem.mem_ready = 1; mem.mem_rdata = 32'hDEADBEEF;
        cycle();
        check("zl_req",  32'(mem.mem_req), 32'd1);
        check("zl_addr", mem.mem_addr, 32'h100);
        cycle();
        check("zl_valid", 32'(load_valid), 32'd1);
        check("zl_data",  load_data, 32'hDEADBEEF);
        cycle();
        idle_inputs();
        cycle();
        cycle();

        // Store with two wait cycles
        MemWrite = 1; wdata = 32'h55; addr = 32'h200; mem.mem_ready = 0;
        cycle(); cycle(); cycle();
        mem.mem_ready = 1;
        cycle();
        cycle();
        idle_inputs();
        cycle();

        // Store forwarding hit, then rd=x0 which must not forward
        for (int k = 0; k < 2; k++) begin
            MemWrite = 1; EX_MEM_rs2 = 5'd5; MEM_WB_rd = (k == 0) ? 5'd5 : 5'd0;
            MEM_WB_RegWrite = 1; wb_data = 32'h1234; wdata = 32'h9999; mem.mem_ready = 1;
            cycle();
            check("fwd_wdata", mem.mem_wdata, (k == 0) ? 32'h1234 : 32'h9999);
            cycle();
            cycle();
            idle_inputs();
            cycle();
        end

        // Flush in IDLE: nothing issued
        MemRead = 1; flush = 1; addr = 32'h300;
        cycle();
        check("flush_idle_req", 32'(mem.mem_req), 32'd0);
        // Flush during REQ of a load: completes, no valid
        flush = 0; mem.mem_ready = 0;
        cycle();
        flush = 1;
        cycle();
        flush = 0; mem.mem_ready = 1; mem.mem_rdata = 32'hCAFEF00D;
        cycle();
        check("flush_req_valid", 32'(load_valid), 32'd0);
        idle_inputs();
        cycle();
        cycle();

        // Async reset while REQ is outstanding
        MemRead = 1; addr = 32'h400; mem.mem_ready = 0;
        cycle();
        rst = 1;
        #1;
        check("arst_req",   32'(mem.mem_req), 32'd0);
        check("arst_stall", 32'(mem_stall), 32'd0);
        check("arst_addr",  mem.mem_addr, 32'd0);
        @(posedge clk); #1;
        rst = 0;
        idle_inputs();
        model_reset();
        cycle();

        // Back-to-back load then store, zero-wait
        MemRead = 1; addr = 32'h500; mem.mem_ready = 1; mem.mem_rdata = 32'h0BADF00D;
        cycle();
        cycle();
        MemRead = 0; MemWrite = 1; addr = 32'h504; wdata = 32'h77;
        cycle();
        cycle();
        cycle();
        cycle();
        idle_inputs();
        cycle();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            MemRead         = ($urandom_range(0, 9) < 4);
            MemWrite        = ($urandom_range(0, 9) < 4);
            flush           = ($urandom_range(0, 9) == 0);
            addr            = $urandom;
            wdata           = $urandom;
            wb_data         = $urandom;
            EX_MEM_rs2      = 5'($urandom_range(0, 3));
            MEM_WB_rd       = 5'($urandom_range(0, 3));
            MEM_WB_RegWrite = 1'($urandom_range(0, 1));
            mem.mem_ready   = 1'($urandom_range(0, 1));
            mem.mem_rdata   = $urandom;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Memory-stage data-memory access controller for the 5-stage RISC-V pipeline. Sequences each load/store in the MEM stage onto a multi-cycle data-memory port with a req/ready handshake and stalls the pipeline until the access completes. Resolves WB→MEM store-data forwarding at issue time and returns registered load data to the MEM/WB latch. Sits between the EX/MEM pipeline register, the hazard unit (stall/flush) and the data memory.

## Interface
- XLEN, 32, data/address width
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- MemRead  in  1  MEM-stage instruction is a load
- MemWrite  in  1  MEM-stage instruction is a store
- addr  in  XLEN  effective address from EX/MEM
- wdata  in  XLEN  store data from EX/MEM (unforwarded)
- EX_MEM_rs2  in  5  store-data source register
- MEM_WB_rd  in  5  WB-stage destination register
- MEM_WB_RegWrite  in  1  WB-stage writes rd
- wb_data  in  XLEN  WB-stage writeback value
- flush  in  1  squash MEM-stage instruction
- mem_req  out  1  access request to data memory
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  XLEN  access address
- mem_wdata  out  XLEN  write data
- mem_ready  in  1  memory accepts/completes access this cycle
- mem_rdata  in  XLEN  read data, valid when mem_req & mem_ready
- mem_stall  out  1  freeze IF..MEM stages
- load_data  out  XLEN  registered load result
- load_valid  out  1  one-cycle pulse, load_data valid

## Operation
- FSM states: IDLE, REQ, DONE.
- access = (MemRead | MemWrite) & ~flush.
- IDLE: if access → latch mem_addr=addr, mem_we=MemWrite & ~MemRead, mem_wdata=fwd ? wb_data : wdata; clear flushed flag; → REQ. Else stay.
- fwd = MemWrite & MEM_WB_RegWrite & (MEM_WB_rd != 0) & (MEM_WB_rd == EX_MEM_rs2); evaluated only on the IDLE→REQ edge.
- MemRead & MemWrite both high: treated as load (mem_we=0), no write issued.
- REQ: mem_req=1; addr/we/wdata held stable. On mem_req & mem_ready → capture load_data=mem_rdata if read; → DONE. Else stay.
- flush while in REQ: access still completes (no request withdrawal); set flushed flag; load_valid suppressed.
- DONE: load_valid=1 iff read and not flushed; → IDLE unconditionally (no reissue even though MemRead still high this cycle).
- mem_stall = ~rst & ((state==IDLE & access) | state==REQ). Low in DONE, so pipeline advances exactly once per access.
- mem_ready ignored when mem_req=0.

## Timing
- Reset (async, immediate): state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, load_data=0, load_valid=0, flushed=0; mem_stall=0 while rst high.
- Reset mid-transfer: mem_req drops asynchronously; access abandoned, no completion.
- Zero-wait memory (mem_ready high on first REQ cycle): instruction spends 3 cycles in MEM — IDLE/issue (stall), REQ (stall), DONE (no stall).
- N wait cycles: MEM occupancy = 3 + N cycles.
- load_data updated on the REQ→DONE edge; held until next completed load; load_valid high only in DONE cycle.
- Non-memory instruction in IDLE: no stall, zero added latency.
- Back-to-back accesses: DONE→IDLE→REQ; next access issues in the cycle after DONE.
- flush in IDLE with access pending: no issue, no stall.

## Test plan
- Zero-wait load: MemRead=1, addr=0x100, mem_ready=1, mem_rdata=0xDEADBEEF → mem_req one cycle with mem_we=0, mem_addr=0x100; stall 2 cycles; load_valid pulse with load_data=0xDEADBEEF.
- Store with 2 wait cycles: MemWrite=1, wdata=0x55, mem_ready low 2 REQ cycles → mem_req held 3 cycles, addr/wdata stable; stall 4 cycles; no load_valid.
- Store forwarding: EX_MEM_rs2=5, MEM_WB_rd=5, MEM_WB_RegWrite=1, wb_data=0x1234, wdata=0x9999 → mem_wdata=0x1234; repeat with MEM_WB_rd=0 → mem_wdata=0x9999.
- Flush: flush in IDLE with MemRead → no mem_req, no stall; flush during REQ of a load → request completes, load_valid stays 0.
- Async reset asserted in REQ: mem_req, mem_stall drop same cycle; state IDLE; all outputs zero after release.
- Back-to-back load then store, zero-wait → two distinct mem_req cycles separated by DONE and IDLE; load_valid only for the load.
